controle_memoria: RTL
=====================

CONTROLE_MEMORIA -- requirements
Module: controle_memoria

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory access length in cycles, legal range 1..7.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports are named clock and reset.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_busca  in  1  instruction-fetch request, level, held until busca_pronta.
REQ-007 req_dado  in  1  data-access request from MEM stage, level, held until dado_pronto.
REQ-008 dado_escrita  in  1  with req_dado: 1 = store, 0 = load.
REQ-009 fonte_wb  in  1  store write-data source: 1 = MEM/WB value, 0 = register value.
REQ-010 PCescreve  out  1  PC load enable.
REQ-011 c1  out  1  address mux select: 1 = ALU address (data), 0 = PC adder (fetch).
REQ-012 c2  out  1  write-data mux select.
REQ-013 ler  out  1  memory read strobe.
REQ-014 escreve  out  1  memory write strobe.
REQ-015 busca_pronta  out  1  one-cycle pulse, fetch complete.
REQ-016 dado_pronto  out  1  one-cycle pulse, data access complete.
REQ-017 ocupado  out  1  high in any non-idle state.
REQ-018 cont_bolhas  out  CNT_W  saturating count of fetch-stall cycles.

Function
REQ-019 SHALL implement FSM states OCIOSO, BUSCA, DADO_LER, DADO_ESCR; one shared memory port, one access at a time.
REQ-020 Grant decision SHALL be taken in OCIOSO and on the last cycle of any access (back-to-back, no idle bubble).
REQ-021 Grant priority: data over fetch, except when both are pending and the previous completed grant was data, then fetch wins (strict alternation under contention).
REQ-022 Granted data request SHALL enter DADO_ESCR if dado_escrita=1, else DADO_LER; dado_escrita and fonte_wb are latched at grant.
REQ-023 Each access state SHALL last exactly MEM_LAT cycles, counted by an internal 3-bit counter.
REQ-024 Outputs SHALL be decoded from state only (Moore): ler=1 in BUSCA and DADO_LER; escreve=1 in DADO_ESCR; c1=1 in DADO_*; c2 = latched fonte_wb in DADO_ESCR, else 0.
REQ-025 busca_pronta/dado_pronto SHALL be high on the last cycle of BUSCA/DADO_* respectively; PCescreve SHALL equal busca_pronta.
REQ-026 Latency: request sampled at edge n from OCIOSO -> access occupies cycles n+1..n+MEM_LAT -> pronto in cycle n+MEM_LAT.
REQ-027 Request deasserted mid-access SHALL NOT abort it; the access completes and pronto still pulses.
REQ-028 ler and escreve SHALL never be high together; c1 SHALL be stable for the whole access.
REQ-029 cont_bolhas SHALL increment each cycle req_busca=1 and state is DADO_*, saturating at 2^CNT_W-1 with no wrap.

Reset
REQ-030 reset=1 SHALL force OCIOSO immediately, independent of clock, with all outputs 0, cont_bolhas 0, alternation flag cleared (data priority).
REQ-031 Reset mid-access SHALL abandon the access with no pronto pulse; first grant is evaluated on the first rising edge after reset release.

Structure
REQ-032 Package controle_memoria_pkg SHALL hold the state enumeration and the MEM_LAT default.
REQ-033 Sub-module contador_saturado (parameterised width, enable, synchronous clear, async reset) SHALL implement cont_bolhas.

Verification
REQ-034 MEM_LAT=2, req_busca alone at cycle 0 -> ler=1, c1=0 in cycles 1-2; busca_pronta=PCescreve=1 in cycle 2 only.
REQ-035 req_dado=1, dado_escrita=1, fonte_wb=1 -> escreve=1, c1=1, c2=1, ler=0 for 2 cycles; dado_pronto in the last one.
REQ-036 Both requests held for 12 cycles -> grants D,F,D,F (each 2 cycles, no gaps); cont_bolhas=2 after the first data access.
REQ-037 Reset asserted in cycle 1 of BUSCA -> all outputs 0 same cycle; no busca_pronta; re-grant 1 cycle after release.
REQ-038 CNT_W=2, data held with fetch pending for 8 stall cycles -> cont_bolhas stays 3, no wrap.
REQ-039 MEM_LAT=1, req_dado load dropped after the grant edge -> DADO_LER 1 cycle, dado_pronto=1, then OCIOSO.

Source files
------------

// File: rtl/controle_memoria_pkg.sv
// Purpose : shared types and defaults for the memory-port controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package controle_memoria_pkg;

    // One shared memory port; the state says who owns it this cycle.
    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        BUSCA     = 2'd1,
        DADO_LER  = 2'd2,
        DADO_ESCR = 2'd3
    } estado_t;

    localparam int MEM_LAT_PADRAO = 2;   // access length in cycles (1..7)
    localparam int CNT_W_PADRAO   = 16;  // stall counter width

endpackage

// File: rtl/controle_memoria_if.sv
// Purpose : request/strobe bundle between pipeline and memory controller.
// Latency : n/a (wires only).
// Backpressure: requests are levels held until the matching pronto pulse.
//   master : pipeline side, drives req_busca/req_dado/dado_escrita/fonte_wb
//   slave  : controller side, drives PCescreve/c1/c2/ler/escreve/pronto/ocupado/cont_bolhas
interface controle_memoria_if #(
    parameter int CNT_W = 16
);
    logic             req_busca;
    logic             req_dado;
    logic             dado_escrita;
    logic             fonte_wb;
    logic             PCescreve;
    logic             c1;
    logic             c2;
    logic             ler;
    logic             escreve;
    logic             busca_pronta;
    logic             dado_pronto;
    logic             ocupado;
    logic [CNT_W-1:0] cont_bolhas;

    modport master (
        output req_busca, req_dado, dado_escrita, fonte_wb,
        input  PCescreve, c1, c2, ler, escreve, busca_pronta, dado_pronto,
               ocupado, cont_bolhas
    );

    modport slave (
        input  req_busca, req_dado, dado_escrita, fonte_wb,
        output PCescreve, c1, c2, ler, escreve, busca_pronta, dado_pronto,
               ocupado, cont_bolhas
    );
endinterface

// File: rtl/controle_memoria_contador_saturado.sv
// Purpose : saturating up-counter (stops at all-ones, never wraps).
// Latency : count visible the cycle after an enabled edge.
// Backpressure: none; en_i is sampled every cycle.
//   clock, reset (async, active-high), en_i increment, clr_i sync clear, cont_o value
module contador_saturado #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cont_o
);
    logic [W-1:0] cont_q;
    logic [W-1:0] cont_d;

    always_comb begin
        cont_d = cont_q;
        if (clr_i) begin
            cont_d = '0;
        end else if (en_i && (cont_q != '1)) begin
            cont_d = cont_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign cont_o = cont_q;
endmodule

// File: rtl/controle_memoria.sv
// Purpose : arbitrates one memory port between instruction fetch and MEM-stage data access.
// Latency : grant at edge n, access cycles n+1..n+MEM_LAT, pronto on the last one.
// Backpressure: requesters hold their level until pronto; losers simply wait (stall counted).
//   clock, reset (async, active-high); bus: controle_memoria_if.slave (requests in, strobes out)
module controle_memoria
    import controle_memoria_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_PADRAO,
    parameter int CNT_W   = CNT_W_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    controle_memoria_if.slave bus
);
    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_invalida
        $error("MEM_LAT must be in 1..7");
    end

    localparam logic [2:0] ULTIMO = 3'(MEM_LAT - 1);

    estado_t    estado_q, estado_d;
    logic [2:0] cnt_q, cnt_d;
    logic       wb_q, wb_d;            // fonte_wb captured at data grant
    logic       ult_dado_q, ult_dado_d; // most recent grant went to data

    logic em_acesso;
    logic em_dado;
    logic ultimo;
    logic decide;

    assign em_acesso = (estado_q != OCIOSO);
    assign em_dado   = (estado_q == DADO_LER) || (estado_q == DADO_ESCR);
    assign ultimo    = em_acesso && (cnt_q == ULTIMO);
    // Arbitrate when idle and on the final access cycle, so accesses chain with no bubble.
    assign decide    = !em_acesso || ultimo;

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        wb_d       = wb_q;
        ult_dado_d = ult_dado_q;
        if (decide) begin
            cnt_d = 3'd0;
            // Data normally wins; under contention, fetch wins right after a data grant.
            // On the last cycle of an access ult_dado_q describes the access now completing.
            if (bus.req_dado && !(bus.req_busca && ult_dado_q)) begin
                estado_d   = bus.dado_escrita ? DADO_ESCR : DADO_LER;
                wb_d       = bus.fonte_wb;
                ult_dado_d = 1'b1;
            end else if (bus.req_busca) begin
                estado_d   = BUSCA;
                ult_dado_d = 1'b0;
            end else begin
                estado_d   = OCIOSO;
            end
        end else begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            cnt_q      <= 3'd0;
            wb_q       <= 1'b0;
            ult_dado_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            wb_q       <= wb_d;
            ult_dado_q <= ult_dado_d;
        end
    end

    // Moore outputs: decoded from registered state only.
    assign bus.ler          = (estado_q == BUSCA) || (estado_q == DADO_LER);
    assign bus.escreve      = (estado_q == DADO_ESCR);
    assign bus.c1           = em_dado;
    assign bus.c2           = (estado_q == DADO_ESCR) && wb_q;
    assign bus.busca_pronta = (estado_q == BUSCA) && ultimo;
    assign bus.dado_pronto  = em_dado && ultimo;
    assign bus.PCescreve    = bus.busca_pronta;
    assign bus.ocupado      = em_acesso;

    contador_saturado #(
        .W (CNT_W)
    ) u_bolhas (
        .clock  (clock),
        .reset  (reset),
        .en_i   (em_dado && bus.req_busca),
        .clr_i  (1'b0),
        .cont_o (bus.cont_bolhas)
    );
endmodule
